// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared constants and blanking helper for seven-segment digit scanners
package seven_seg_pkg;

  localparam int DIGIT_W    = 4;
  localparam int MIN_DIGITS = 2;
  localparam int MAX_DIGITS = 8;
  localparam int VALUE_MAX_W = DIGIT_W * MAX_DIGITS;

  // Bit i set means digit i is a leading zero and should be dark.
  // Digit 0 is never blanked so an all-zero value still shows a single "0".
  function automatic logic [MAX_DIGITS-1:0] lz_blank_mask(
    input logic [VALUE_MAX_W-1:0] value,
    input int                     num_digits
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  all_zero;
    mask     = '0;
    all_zero = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < num_digits) begin
        all_zero = all_zero & (value[i*DIGIT_W +: DIGIT_W] == '0);
        mask[i]  = all_zero;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/seven_seg_refresh_timer.sv
// rtl/seven_seg_refresh_timer.sv - digit slot prescaler with slot tick and dead-time flag
module seven_seg_refresh_timer #(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic dead
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] count;

  // Free-running slot counter, 0..REFRESH_DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (count == LAST_COUNT) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST_COUNT);

  // Dead time covers the first DEAD_CYCLES counts of every slot.
  if (DEAD_CYCLES == 0) begin : g_no_dead
    assign dead = 1'b0;
  end else begin : g_dead
    localparam logic [CNT_W-1:0] DEAD_LIMIT = CNT_W'(DEAD_CYCLES);
    assign dead = (count < DEAD_LIMIT);
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - multiplexed digit scanner with frame-synchronous value updates
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 500,
  parameter int BLANK_LZ    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] value_in,
  input  logic                          load,
  output logic [DIGIT_W-1:0]            nibble_out,
  output logic [NUM_DIGITS-1:0]         digit_en_n,
  output logic                          frame_done,
  output logic                          pending
);

  localparam int VALUE_W = DIGIT_W * NUM_DIGITS;
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic                  tick;
  logic                  dead;
  logic [IDX_W-1:0]      index;
  logic                  frame_boundary;
  logic [VALUE_W-1:0]    display;
  logic [VALUE_W-1:0]    pend_value;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic [DIGIT_W-1:0]    nibble_next;
  logic [NUM_DIGITS-1:0] en_n_next;

  seven_seg_refresh_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .dead (dead)
  );

  assign frame_boundary = tick && (index == LAST_IDX);

  // Digit index advances once per slot and wraps after the last digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      index <= '0;
    end else if (tick) begin
      index <= (index == LAST_IDX) ? '0 : index + 1'b1;
    end
  end

  // Loads are parked until the frame boundary so a frame never mixes old and new digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      display    <= '0;
      pend_value <= '0;
      pending    <= 1'b0;
    end else if (load && frame_boundary) begin
      display <= value_in;
      pending <= 1'b0;
    end else if (load) begin
      pend_value <= value_in;
      pending    <= 1'b1;
    end else if (frame_boundary && pending) begin
      display <= pend_value;
      pending <= 1'b0;
    end
  end

  if (BLANK_LZ != 0) begin : g_blank
    logic [VALUE_MAX_W-1:0] display_wide;
    logic [MAX_DIGITS-1:0]  mask_full;
    assign display_wide = VALUE_MAX_W'(display);
    assign mask_full    = lz_blank_mask(display_wide, NUM_DIGITS);
    assign blank_mask   = mask_full[NUM_DIGITS-1:0];
  end else begin : g_no_blank
    assign blank_mask = '0;
  end

  // Next-cycle nibble and enables from the current index, dead time and blanking.
  always_comb begin
    en_n_next   = '1;
    nibble_next = display[index*DIGIT_W +: DIGIT_W];
    if (!dead && !blank_mask[index]) begin
      en_n_next[index] = 1'b0;
    end
  end

  // Output registers give the decoder and digit drivers glitch-free signals.
  always_ff @(posedge clk) begin
    if (rst) begin
      nibble_out <= '0;
      digit_en_n <= '1;
      frame_done <= 1'b0;
    end else begin
      nibble_out <= nibble_next;
      digit_en_n <= en_n_next;
      frame_done <= frame_boundary;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - scoreboard bench for seven_seg_scanner
module tb_seven_seg_scanner;

  localparam int N    = 4;
  localparam int DIV  = 4;
  localparam int DEAD = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  nibble_out;
  logic [3:0]  digit_en_n;
  logic        frame_done;
  logic        pending;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (DIV),
    .DEAD_CYCLES (DEAD),
    .BLANK_LZ    (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value_in   (value_in),
    .load       (load),
    .nibble_out (nibble_out),
    .digit_en_n (digit_en_n),
    .frame_done (frame_done),
    .pending    (pending)
  );

  typedef struct packed {
    logic [3:0] nib;
    logic [3:0] en;
    logic       fd;
    logic       pend;
    logic       slot_start;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int          m_pre;
  int          m_idx;
  logic [15:0] m_disp;
  logic [15:0] m_pval;
  logic        m_pend;

  int         obs_cnt[4];
  logic [3:0] obs_nib[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_en();
    if (m_pre < DEAD) return 4'hF;
    if (m_idx > 0 && (m_disp >> (4 * m_idx)) == 16'h0) return 4'hF;
    return ~(4'b0001 << m_idx);
  endfunction

  task automatic cycle();
    exp_t e;
    logic tick;
    logic fb;
    e = '0;
    if (rst) begin
      e.nib = 4'h0; e.en = 4'hF; e.fd = 1'b0; e.pend = 1'b0; e.slot_start = 1'b1;
      m_pre = 0; m_idx = 0; m_disp = '0; m_pval = '0; m_pend = 1'b0;
    end else begin
      tick = (m_pre == DIV - 1);
      fb   = tick && (m_idx == N - 1);
      e.nib = m_disp[4*m_idx +: 4];
      e.en  = model_en();
      e.fd  = fb;
      e.slot_start = (m_pre == 0);
      if (load && fb) begin
        m_disp = value_in; m_pend = 1'b0;
      end else if (load) begin
        m_pval = value_in; m_pend = 1'b1;
      end else if (fb && m_pend) begin
        m_disp = m_pval; m_pend = 1'b0;
      end
      e.pend = m_pend;
      if (tick) begin
        m_pre = 0;
        m_idx = (m_idx + 1) % N;
      end else begin
        m_pre++;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("nibble_out", nibble_out, e.nib);
    check("digit_en_n", digit_en_n, e.en);
    check("frame_done", frame_done, e.fd);
    check("pending", pending, e.pend);
    check("one_low", $countones(~digit_en_n) <= 1, 1);
    if (e.slot_start) check("dead_p0", digit_en_n, 4'hF);
  endtask

  task automatic wait_frame();
    int k = 0;
    do begin
      cycle();
      k++;
    end while (!frame_done && k < 40);
    check("frame_wait", frame_done, 1);
  endtask

  task automatic observe(input int ncyc);
    for (int i = 0; i < 4; i++) begin
      obs_cnt[i] = 0;
      obs_nib[i] = 4'hX;
    end
    repeat (ncyc) begin
      cycle();
      for (int i = 0; i < 4; i++) begin
        if (!digit_en_n[i]) begin
          obs_cnt[i]++;
          obs_nib[i] = nibble_out;
        end
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [15:0] shown, input logic [3:0] lit);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_cnt"}, obs_cnt[i], lit[i] ? 3 : 0);
      if (lit[i]) check({tag, "_nib"}, obs_nib[i], shown[4*i +: 4]);
    end
  endtask

  initial begin
    int k;
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;

    // idle after reset: only digit 0 lit, showing 0, frame every 16 cycles
    repeat (32) cycle();
    wait_frame();
    k = 0;
    do begin
      cycle();
      k++;
    end while (!frame_done && k < 40);
    check("fd_period", k, 16);
    observe(16);
    check_frame("idle", 16'h0000, 4'b0001);

    // load mid-frame, appears at the next boundary
    repeat (5) cycle();
    value_in = 16'h1234; load = 1'b1;
    cycle();
    load = 1'b0;
    check("pend_set", pending, 1);
    wait_frame();
    check("pend_clr", pending, 0);
    observe(16);
    check_frame("v1234", 16'h1234, 4'b1111);

    // leading zeros blanked, inner zero digit 0 still shown
    repeat (5) cycle();
    value_in = 16'h00A0; load = 1'b1;
    cycle();
    load = 1'b0;
    wait_frame();
    observe(16);
    check_frame("v00a0", 16'h00A0, 4'b0011);

    // two loads in one frame: last write wins
    repeat (3) cycle();
    value_in = 16'h1111; load = 1'b1;
    cycle();
    load = 1'b0;
    cycle();
    value_in = 16'h2222; load = 1'b1;
    cycle();
    load = 1'b0;
    wait_frame();
    observe(16);
    check_frame("v2222", 16'h2222, 4'b1111);

    // load exactly on the boundary tick goes straight to the display
    k = 0;
    while (!(m_pre == DIV - 1 && m_idx == N - 1) && k < 40) begin
      cycle();
      k++;
    end
    check("fb_reach", (m_pre == DIV - 1 && m_idx == N - 1), 1);
    value_in = 16'h5678; load = 1'b1;
    cycle();
    load = 1'b0;
    check("fb_pend", pending, 0);
    check("fb_done", frame_done, 1);
    observe(16);
    check_frame("v5678", 16'h5678, 4'b1111);

    // reset mid-slot with a pending value discards everything
    repeat (2) cycle();
    value_in = 16'h9999; load = 1'b1;
    cycle();
    load = 1'b0;
    check("rst_pend_before", pending, 1);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_en", digit_en_n, 4'hF);
    check("rst_nib", nibble_out, 0);
    check("rst_pend", pending, 0);
    wait_frame();
    observe(16);
    check_frame("post_rst", 16'h0000, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
